// File: rtl/router_pkg.sv
// ---------------------------------------------------------------------------
// router_pkg
// Shared definitions for the 1x3 router and its packet transmitter:
//   - tx_state_e    : transmitter FSM states
//   - ADDR_ILLEGAL  : destination code that no output port answers to
//   - MAX_LEN       : largest payload length the 6-bit length field carries
//   - BUF_DEPTH     : payload buffer depth (one entry per length code)
//   - hdr_pack / hdr_len / hdr_addr : header byte {len[5:0], addr[1:0]}
//   - parity_acc    : running XOR parity accumulator step
// ---------------------------------------------------------------------------
package router_pkg;

    localparam int         MAX_LEN      = 63;
    localparam int         BUF_DEPTH    = 64;
    localparam logic [1:0] ADDR_ILLEGAL = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SEND_HDR = 3'd2,
        ST_SEND_PL  = 3'd3,
        ST_SEND_PAR = 3'd4
    } tx_state_e;

    function automatic logic [7:0] hdr_pack(input logic [5:0] len, input logic [1:0] addr);
        return {len, addr};
    endfunction

    function automatic logic [5:0] hdr_len(input logic [7:0] hdr);
        return hdr[7:2];
    endfunction

    function automatic logic [1:0] hdr_addr(input logic [7:0] hdr);
        return hdr[1:0];
    endfunction

    function automatic logic [7:0] parity_acc(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/router_tx_buf.sv
// ---------------------------------------------------------------------------
// router_tx_buf
// Payload staging buffer: 64 x 8 register array, one synchronous write port
// and one combinational read port. Contents are not reset; every entry that
// is read was written earlier in the same packet.
// Ports:
//   clock   : rising-edge clock
//   we      : write enable
//   wr_addr : write address
//   wr_data : write data
//   rd_addr : read address
//   rd_data : read data (combinational)
// ---------------------------------------------------------------------------
module router_tx_buf
    import router_pkg::*;
(
    input  logic       clock,
    input  logic       we,
    input  logic [5:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic [5:0] rd_addr,
    output logic [7:0] rd_data
);

    logic [7:0] mem_r [BUF_DEPTH];

    // Storage write port
    always_ff @(posedge clock) begin
        if (we) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/router_pkt_tx.sv
// ---------------------------------------------------------------------------
// router_pkt_tx
// Packet transmitter feeding the router input port. Accepts a request
// (destination, length), buffers the payload from a local byte stream, then
// sends header, payload (pkt_valid high) and parity (pkt_valid low),
// holding each byte while the router asserts busy.
// Ports:
//   clock, resetn            : clock, asynchronous active-low reset
//   start, dest_addr,
//   payload_len, inject_err  : packet request (sampled in IDLE)
//   pl_data, pl_valid        : payload byte stream in
//   pl_ready                 : payload byte accepted this cycle
//   busy                     : router back-pressure
//   data_out, pkt_valid      : byte-serial output to the router
//   tx_active                : block is not idle
//   done                     : one-cycle pulse after parity is taken
//   start_err                : one-cycle pulse for an illegal request
// ---------------------------------------------------------------------------
module router_pkt_tx #(
    parameter int MAX_LEN = router_pkg::MAX_LEN
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [1:0] dest_addr,
    input  logic [5:0] payload_len,
    input  logic       inject_err,
    input  logic [7:0] pl_data,
    input  logic       pl_valid,
    output logic       pl_ready,
    input  logic       busy,
    output logic [7:0] data_out,
    output logic       pkt_valid,
    output logic       tx_active,
    output logic       done,
    output logic       start_err
);

    import router_pkg::*;

    tx_state_e  state_r;
    logic [7:0] header_r;
    logic [7:0] parity_r;
    logic       inj_r;
    logic [5:0] ld_cnt_r;
    logic [5:0] rd_ptr_r;

    logic       start_legal_s;
    logic       buf_we_s;
    logic [5:0] buf_rd_addr_s;
    logic [7:0] buf_rd_data_s;
    logic [5:0] last_idx_s;

    // Request legality: reject the illegal destination and out-of-range lengths
    always_comb begin
        start_legal_s = 1'b0;
        if ((dest_addr != ADDR_ILLEGAL) && (payload_len != 6'd0) &&
            (int'(payload_len) <= MAX_LEN)) begin
            start_legal_s = 1'b1;
        end else begin
            start_legal_s = 1'b0;
        end
    end

    // Buffer write strobe and look-ahead read address. data_out is
    // registered, so the read port addresses the byte to present next.
    always_comb begin
        buf_we_s      = 1'b0;
        buf_rd_addr_s = 6'd0;
        if (state_r == ST_LOAD) begin
            buf_we_s = pl_valid & pl_ready;
        end else begin
            buf_we_s = 1'b0;
        end
        if (state_r == ST_SEND_PL) begin
            buf_rd_addr_s = rd_ptr_r + 6'd1;
        end else begin
            buf_rd_addr_s = 6'd0;
        end
    end

    assign last_idx_s = hdr_len(header_r) - 6'd1;

    router_tx_buf u_buf (
        .clock   (clock),
        .we      (buf_we_s),
        .wr_addr (ld_cnt_r),
        .wr_data (pl_data),
        .rd_addr (buf_rd_addr_s),
        .rd_data (buf_rd_data_s)
    );

    // Transmit FSM with counters, parity accumulator and registered outputs
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_r   <= ST_IDLE;
            header_r  <= 8'd0;
            parity_r  <= 8'd0;
            inj_r     <= 1'b0;
            ld_cnt_r  <= 6'd0;
            rd_ptr_r  <= 6'd0;
            data_out  <= 8'd0;
            pkt_valid <= 1'b0;
            pl_ready  <= 1'b0;
            tx_active <= 1'b0;
            done      <= 1'b0;
            start_err <= 1'b0;
        end else begin
            done      <= 1'b0;
            start_err <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        if (start_legal_s) begin
                            header_r  <= hdr_pack(payload_len, dest_addr);
                            parity_r  <= hdr_pack(payload_len, dest_addr);
                            inj_r     <= inject_err;
                            ld_cnt_r  <= 6'd0;
                            rd_ptr_r  <= 6'd0;
                            pl_ready  <= 1'b1;
                            tx_active <= 1'b1;
                            state_r   <= ST_LOAD;
                        end else begin
                            start_err <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (pl_valid && pl_ready) begin
                        parity_r <= parity_acc(parity_r, pl_data);
                        ld_cnt_r <= ld_cnt_r + 6'd1;
                        if (ld_cnt_r == last_idx_s) begin
                            pl_ready  <= 1'b0;
                            pkt_valid <= 1'b1;
                            data_out  <= header_r;
                            state_r   <= ST_SEND_HDR;
                        end
                    end
                end
                ST_SEND_HDR: begin
                    // Read port points at entry 0 while the header is out
                    if (!busy) begin
                        rd_ptr_r <= 6'd0;
                        data_out <= buf_rd_data_s;
                        state_r  <= ST_SEND_PL;
                    end
                end
                ST_SEND_PL: begin
                    if (!busy) begin
                        if (rd_ptr_r == last_idx_s) begin
                            pkt_valid <= 1'b0;
                            data_out  <= parity_r ^ {7'b0000000, inj_r};
                            state_r   <= ST_SEND_PAR;
                        end else begin
                            rd_ptr_r <= rd_ptr_r + 6'd1;
                            data_out <= buf_rd_data_s;
                        end
                    end
                end
                ST_SEND_PAR: begin
                    if (!busy) begin
                        data_out  <= 8'd0;
                        tx_active <= 1'b0;
                        done      <= 1'b1;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    data_out  <= 8'd0;
                    pkt_valid <= 1'b0;
                    pl_ready  <= 1'b0;
                    tx_active <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_router_pkt_tx.sv
// ---------------------------------------------------------------------------
// tb_router_pkt_tx
// Scoreboard bench for router_pkt_tx. Each packet request pushes the
// expected byte stream (header, payload, parity) onto a queue; a monitor
// pops and compares every byte the router side takes (busy low, block in a
// send phase) and checks that output bytes hold while busy is high.
// ---------------------------------------------------------------------------
module tb_router_pkt_tx;

    logic       clock;
    logic       resetn;
    logic       start;
    logic [1:0] dest_addr;
    logic [5:0] payload_len;
    logic       inject_err;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       pl_ready;
    logic       busy;
    logic [7:0] data_out;
    logic       pkt_valid;
    logic       tx_active;
    logic       done;
    logic       start_err;

    typedef struct packed {
        logic [7:0] data;
        logic       pv;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] pl_bytes [64];
    int         n_chk     = 0;
    int         n_fail    = 0;
    int         done_cnt  = 0;
    int         exp_done  = 0;
    int         err_cnt   = 0;
    int         err_exp   = 0;
    int         busy_mode = 0;

    router_pkt_tx dut (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start),
        .dest_addr   (dest_addr),
        .payload_len (payload_len),
        .inject_err  (inject_err),
        .pl_data     (pl_data),
        .pl_valid    (pl_valid),
        .pl_ready    (pl_ready),
        .busy        (busy),
        .data_out    (data_out),
        .pkt_valid   (pkt_valid),
        .tx_active   (tx_active),
        .done        (done),
        .start_err   (start_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: byte transfers, hold-while-busy, done/start_err pulse counts
    initial begin
        exp_t       e;
        logic       hold_v;
        logic [7:0] hold_d;
        logic       hold_pv;
        logic       send;
        hold_v = 1'b0;
        hold_d = 8'd0;
        hold_pv = 1'b0;
        forever begin
            @(negedge clock);
            if (resetn === 1'b1) begin
                send = tx_active && !pl_ready;
                if (done)      done_cnt++;
                if (start_err) err_cnt++;
                if (hold_v && send) begin
                    chk("hold_data_out", {24'd0, data_out}, {24'd0, hold_d});
                    chk("hold_pkt_valid", {31'd0, pkt_valid}, {31'd0, hold_pv});
                end
                hold_v = 1'b0;
                if (send && busy) begin
                    hold_v  = 1'b1;
                    hold_d  = data_out;
                    hold_pv = pkt_valid;
                end else if (send) begin
                    if (exp_q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_byte: actual=0x%0h required=none at %0t", data_out, $time);
                    end else begin
                        e = exp_q.pop_front();
                        chk("byte_data", {24'd0, data_out}, {24'd0, e.data});
                        chk("byte_pkt_valid", {31'd0, pkt_valid}, {31'd0, e.pv});
                    end
                end
            end else begin
                hold_v = 1'b0;
            end
        end
    end

    // Router back-pressure generator
    initial begin
        int   sc;
        int   pc;
        logic send;
        sc = 0;
        pc = 0;
        busy = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            send = tx_active && !pl_ready;
            if (!send) begin
                sc = 0;
                pc = 0;
            end
            case (busy_mode)
                1:       busy = ($urandom_range(0, 3) == 0);
                2:       busy = send && ((sc < 5) || (sc >= 8 && sc < 13) || (!pkt_valid && pc < 5));
                default: busy = 1'b0;
            endcase
            if (send) begin
                sc++;
                if (!pkt_valid) pc++;
            end
        end
    end

    // Send one packet; vmode 0 = pl_valid always, 1 = every other cycle, 2 = random
    task automatic send_pkt(input logic [1:0] a, input logic [5:0] l, input logic inj,
                            input int vmode, input bit poke, input bit abort);
        exp_t       e;
        logic [7:0] par;
        int         idx;
        int         cyc;
        bit         v;
        logic       rdy;
        // reference: header is len*4+addr, parity is XOR of everything sent
        par = 8'((int'(l) * 4) + int'(a));
        e.data = par;
        e.pv = 1'b1;
        exp_q.push_back(e);
        for (int i = 0; i < int'(l); i++) begin
            e.data = pl_bytes[i];
            e.pv = 1'b1;
            exp_q.push_back(e);
            par = par ^ pl_bytes[i];
        end
        e.data = par ^ {7'd0, inj};
        e.pv = 1'b0;
        exp_q.push_back(e);

        start = 1'b1;
        dest_addr = a;
        payload_len = l;
        inject_err = inj;
        @(posedge clock);
        #1;
        start = 1'b0;
        inject_err = 1'b0;
        chk("start_pl_ready", {31'd0, pl_ready}, 32'd1);
        chk("start_tx_active", {31'd0, tx_active}, 32'd1);

        idx = 0;
        cyc = 0;
        while (idx < int'(l) && cyc < 2000) begin
            case (vmode)
                0:       v = 1'b1;
                1:       v = cyc[0];
                default: v = ($urandom_range(0, 1) == 1);
            endcase
            pl_valid = v;
            pl_data = pl_bytes[idx];
            if (poke && cyc == 1) begin
                start = 1'b1;
                dest_addr = 2'b11;
            end else begin
                start = 1'b0;
            end
            rdy = pl_ready;
            @(posedge clock);
            #1;
            cyc++;
            if (v && rdy) idx++;
            if (poke && cyc == 2) chk("start_ignored_busy", {31'd0, start_err}, 32'd0);
        end
        pl_valid = 1'b0;
        start = 1'b0;
        chk("load_count", idx, int'(l));

        if (abort) begin
            repeat (3) @(posedge clock);
            #3;
            resetn = 1'b0;
            #1;
            chk("abort_data_out", {24'd0, data_out}, 32'd0);
            chk("abort_pkt_valid", {31'd0, pkt_valid}, 32'd0);
            chk("abort_pl_ready", {31'd0, pl_ready}, 32'd0);
            chk("abort_tx_active", {31'd0, tx_active}, 32'd0);
            chk("abort_done", {31'd0, done}, 32'd0);
            chk("abort_start_err", {31'd0, start_err}, 32'd0);
            exp_q.delete();
            @(posedge clock);
            #1;
            resetn = 1'b1;
        end else begin
            cyc = 0;
            while (!done && cyc < 3000) begin
                @(posedge clock);
                #1;
                cyc++;
            end
            chk("done_seen", {31'd0, done}, 32'd1);
            exp_done++;
        end
    endtask

    task automatic bad_start(input logic [1:0] a, input logic [5:0] l);
        start = 1'b1;
        dest_addr = a;
        payload_len = l;
        @(posedge clock);
        #1;
        start = 1'b0;
        err_exp++;
        chk("start_err_pulse", {31'd0, start_err}, 32'd1);
        chk("start_err_tx_active", {31'd0, tx_active}, 32'd0);
        chk("start_err_pl_ready", {31'd0, pl_ready}, 32'd0);
        @(posedge clock);
        #1;
        chk("start_err_single", {31'd0, start_err}, 32'd0);
        chk("start_err_idle", {31'd0, tx_active}, 32'd0);
    endtask

    task automatic fill_random(input int l);
        for (int i = 0; i < l; i++) pl_bytes[i] = 8'($urandom_range(0, 255));
    endtask

    // Watchdog
    initial begin
        #600000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Main stimulus
    initial begin
        resetn = 1'b0;
        start = 1'b0;
        dest_addr = 2'd0;
        payload_len = 6'd0;
        inject_err = 1'b0;
        pl_data = 8'd0;
        pl_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_data_out", {24'd0, data_out}, 32'd0);
        chk("rst_pkt_valid", {31'd0, pkt_valid}, 32'd0);
        chk("rst_pl_ready", {31'd0, pl_ready}, 32'd0);
        chk("rst_tx_active", {31'd0, tx_active}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_start_err", {31'd0, start_err}, 32'd0);
        resetn = 1'b1;
        @(posedge clock);
        #1;

        busy_mode = 0;
        pl_bytes[0] = 8'h11;
        pl_bytes[1] = 8'h22;
        pl_bytes[2] = 8'h33;
        send_pkt(2'd1, 6'd3, 1'b0, 0, 1'b0, 1'b0);
        send_pkt(2'd1, 6'd3, 1'b1, 0, 1'b0, 1'b0);

        bad_start(2'd3, 6'd5);
        bad_start(2'd1, 6'd0);
        bad_start(2'd3, 6'd0);

        fill_random(63);
        send_pkt(2'd2, 6'd63, 1'b0, 1, 1'b0, 1'b0);

        pl_bytes[0] = 8'hA5;
        send_pkt(2'd0, 6'd1, 1'b0, 0, 1'b0, 1'b0);

        busy_mode = 2;
        fill_random(10);
        send_pkt(2'd1, 6'd10, 1'b0, 0, 1'b1, 1'b0);

        busy_mode = 0;
        fill_random(8);
        send_pkt(2'd2, 6'd8, 1'b0, 0, 1'b0, 1'b1);
        fill_random(5);
        send_pkt(2'd0, 6'd5, 1'b1, 0, 1'b0, 1'b0);

        busy_mode = 1;
        for (int k = 0; k < 6; k++) begin
            int l;
            l = $urandom_range(1, 63);
            fill_random(l);
            send_pkt(2'($urandom_range(0, 2)), 6'(l), 1'($urandom_range(0, 1)), 2, 1'b0, 1'b0);
        end

        busy_mode = 0;
        repeat (5) @(posedge clock);
        #1;
        chk("queue_drained", exp_q.size(), 32'd0);
        chk("done_pulses", done_cnt, exp_done);
        chk("start_err_pulses", err_cnt, err_exp);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
